// File: rtl/scan_transfer_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scan_transfer_buffer_if                                              |
// | Scanner-side and host-side signals of the scan transfer buffer.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface scan_transfer_buffer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [2:0]        s0_state;
  logic [2:0]        s1_state;
  logic [DATA_W-1:0] s0_data;
  logic [DATA_W-1:0] s1_data;
  logic              host_rd;
  logic              buf_flush;
  logic [DATA_W-1:0] host_data;
  logic              host_src;
  logic              host_valid;
  logic [LVL_W-1:0]  fill_level;
  logic              burst_done;
  logic              burst_src;
  logic              overflow;
  logic              short_burst;

  modport master (
    output s0_state, s1_state, s0_data, s1_data, host_rd, buf_flush,
    input  host_data, host_src, host_valid, fill_level,
    input  burst_done, burst_src, overflow, short_burst
  );

  modport slave (
    input  s0_state, s1_state, s0_data, s1_data, host_rd, buf_flush,
    output host_data, host_src, host_valid, fill_level,
    output burst_done, burst_src, overflow, short_burst
  );
endinterface
`default_nettype wire

// File: rtl/scan_transfer_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scan_transfer_buffer                                                 |
// | Captures scanner transfer bursts into a source-tagged FWFT FIFO.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module scan_transfer_buffer #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  scan_transfer_buffer_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int ENT_W  = DATA_W + 1;

  localparam logic [2:0]        TRANSFERRING = 3'b100;
  localparam logic [LVL_W-1:0]  FULL_LVL     = LVL_W'(DEPTH);
  localparam logic [BEAT_W-1:0] BEAT_LAST    = BEAT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_FIRST   = BEAT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CAP0      = 2'd1,
    CAP1      = 2'd2,
    WAIT_EXIT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              src_q, src_d;
  logic              burst_done_q, burst_done_d;
  logic              burst_src_q, burst_src_d;
  logic              overflow_q, overflow_d;
  logic              short_burst_q, short_burst_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  fill_q, fill_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];

  logic              s0_xfer;
  logic              s1_xfer;
  logic              cur_xfer;
  logic              wr_req;
  logic [DATA_W-1:0] wr_word;
  logic              wr_src;
  logic              full;
  logic              rd_fire;
  logic              wr_ok;

  assign s0_xfer  = (bus.s0_state == TRANSFERRING);
  assign s1_xfer  = (bus.s1_state == TRANSFERRING);
  assign cur_xfer = src_q ? s1_xfer : s0_xfer;

  // Capture FSM: src_q remembers which scanner owns the current burst.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    src_d         = src_q;
    burst_done_d  = 1'b0;
    burst_src_d   = burst_src_q;
    short_burst_d = short_burst_q;
    wr_req        = 1'b0;
    wr_word       = bus.s0_data;
    wr_src        = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_xfer || s1_xfer) begin
          src_d   = ~s0_xfer;
          wr_req  = 1'b1;
          wr_word = s0_xfer ? bus.s0_data : bus.s1_data;
          wr_src  = ~s0_xfer;
          beat_d  = BEAT_FIRST;
          if (BURST_LEN == 1) begin
            burst_done_d = 1'b1;
            burst_src_d  = ~s0_xfer;
            state_d      = WAIT_EXIT;
          end else begin
            state_d = s0_xfer ? CAP0 : CAP1;
          end
        end
      end
      CAP0, CAP1: begin
        if (cur_xfer) begin
          wr_req  = 1'b1;
          wr_word = src_q ? bus.s1_data : bus.s0_data;
          wr_src  = src_q;
          beat_d  = beat_q + 1'b1;
          if ((beat_q + 1'b1) == BEAT_LAST) begin
            burst_done_d = 1'b1;
            burst_src_d  = src_q;
            state_d      = WAIT_EXIT;
          end
        end else begin
          burst_done_d  = 1'b1;
          burst_src_d   = src_q;
          short_burst_d = 1'b1;
          state_d       = IDLE;
        end
      end
      WAIT_EXIT: begin
        if (!cur_xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot a full FIFO needs for the write.
  assign full    = (fill_q == FULL_LVL);
  assign rd_fire = bus.host_rd && (fill_q != '0);
  assign wr_ok   = wr_req && (!full || rd_fire) && !bus.buf_flush;

  always_comb begin
    overflow_d = overflow_q | (wr_req && full && !rd_fire);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    if (bus.buf_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_ok, rd_fire})
        2'b10:   fill_d = fill_q + 1'b1;
        2'b01:   fill_d = fill_q - 1'b1;
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      src_q         <= 1'b0;
      burst_done_q  <= 1'b0;
      burst_src_q   <= 1'b0;
      overflow_q    <= 1'b0;
      short_burst_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_q        <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      src_q         <= src_d;
      burst_done_q  <= burst_done_d;
      burst_src_q   <= burst_src_d;
      overflow_q    <= overflow_d;
      short_burst_q <= short_burst_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_q        <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_ptr_q] <= {wr_src, wr_word};
    end
  end

  assign bus.host_data   = mem_q[rd_ptr_q][DATA_W-1:0];
  assign bus.host_src    = mem_q[rd_ptr_q][DATA_W];
  assign bus.host_valid  = (fill_q != '0);
  assign bus.fill_level  = fill_q;
  assign bus.burst_done  = burst_done_q;
  assign bus.burst_src   = burst_src_q;
  assign bus.overflow    = overflow_q;
  assign bus.short_burst = short_burst_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_transfer_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_scan_transfer_buffer                                              |
// | Directed and random bursts checked against a queue-based model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_scan_transfer_buffer;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int BL    = 4;
  localparam logic [2:0] TR = 3'b100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  scan_transfer_buffer_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  scan_transfer_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .BURST_LEN(BL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [DW:0] mq[$];
  bit exp_ovf   = 1'b0;
  bit exp_short = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] idle_st();
    int v;
    v = $urandom_range(0, 6);
    if (v >= 4) v++;
    return 3'(v);
  endfunction

  // One clock of the reference FIFO: head check, edge, then occupancy update.
  task automatic cycle(input bit wr, input logic [DW:0] w, input bit rd, input bit fl);
    bit pop;
    bit was_full;
    pop = rd && (mq.size() > 0);
    was_full = (mq.size() == DEPTH);
    if (pop) begin
      chk("head_data", bus.host_data, mq[0][DW-1:0]);
      chk("head_src", bus.host_src, mq[0][DW]);
    end
    @(posedge clk); #1;
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (wr) begin
        if (!was_full || pop) mq.push_back(w);
        else exp_ovf = 1'b1;
      end
    end
    chk("fill_level", bus.fill_level, mq.size());
    chk("host_valid", bus.host_valid, mq.size() > 0);
    chk("overflow", bus.overflow, exp_ovf);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    bus.s0_state = idle_st();
    bus.s1_state = idle_st();
    bus.host_rd = 1'b0;
    bus.buf_flush = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete();
    exp_ovf = 1'b0;
    exp_short = 1'b0;
  endtask

  // Scanner src transfers for n cycles, then idles for two.
  task automatic run_burst(input bit src, input int n, input bit rd, input bit both, input int flush_t);
    int done_t;
    done_t = (n >= BL) ? BL : n + 1;
    for (int t = 1; t <= n + 2; t++) begin
      logic [DW-1:0] d;
      bit act;
      d = DW'($urandom);
      act = (t <= n);
      if (src == 1'b0) begin
        bus.s0_state = act ? TR : idle_st();
        bus.s0_data  = d;
        bus.s1_state = (both && act) ? TR : idle_st();
        bus.s1_data  = DW'($urandom);
      end else begin
        bus.s1_state = act ? TR : idle_st();
        bus.s1_data  = d;
        bus.s0_state = idle_st();
        bus.s0_data  = DW'($urandom);
      end
      bus.host_rd   = rd;
      bus.buf_flush = (t == flush_t);
      cycle(act && (t <= BL), {src, d}, rd, t == flush_t);
      chk("burst_done", bus.burst_done, t == done_t);
      if (t == done_t) chk("burst_src", bus.burst_src, src);
    end
    if (n < BL) exp_short = 1'b1;
    chk("short_burst", bus.short_burst, exp_short);
    bus.host_rd = 1'b0;
    bus.buf_flush = 1'b0;
  endtask

  task automatic drain();
    bus.s0_state = idle_st();
    bus.s1_state = idle_st();
    bus.host_rd = 1'b1;
    for (int k = 0; k < DEPTH + 2 && mq.size() > 0; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    bus.host_rd = 1'b0;
    chk("drain_empty", bus.host_valid, 1'b0);
  endtask

  task automatic prefill15();
    for (int i = 0; i < 3; i++) run_burst(1'b0, 4, 1'b0, 1'b0, 0);
    run_burst(1'b1, 3, 1'b0, 1'b0, 0);
    chk("prefill_fill", bus.fill_level, 15);
  endtask

  initial begin
    logic [DW-1:0] d0;
    bus.s0_state = 3'b000;
    bus.s1_state = 3'b000;
    bus.s0_data = '0;
    bus.s1_data = '0;
    bus.host_rd = 1'b0;
    bus.buf_flush = 1'b0;
    @(posedge clk); #1;
    reset_dut();
    chk("rst_fill", bus.fill_level, 0);
    chk("rst_valid", bus.host_valid, 0);
    chk("rst_done", bus.burst_done, 0);
    chk("rst_bsrc", bus.burst_src, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_short", bus.short_burst, 0);

    // Full s0 burst.
    run_burst(1'b0, 4, 1'b0, 1'b0, 0);
    chk("full_burst_fill", bus.fill_level, 4);
    drain();

    // Simultaneous request: s0 wins, s1 overlaps WAIT_EXIT and is skipped.
    run_burst(1'b0, 6, 1'b0, 1'b1, 0);
    chk("arb_fill", bus.fill_level, 4);
    drain();

    // Short s1 burst.
    run_burst(1'b1, 2, 1'b0, 1'b0, 0);
    chk("short_fill", bus.fill_level, 2);
    chk("short_flag", bus.short_burst, 1);
    drain();

    // Overflow with no reads, then no overflow with reads held.
    reset_dut();
    prefill15();
    run_burst(1'b0, 4, 1'b0, 1'b0, 0);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_fill", bus.fill_level, 16);
    drain();
    reset_dut();
    prefill15();
    run_burst(1'b0, 4, 1'b1, 1'b0, 0);
    chk("no_ovf_flag", bus.overflow, 0);
    drain();

    // Flush on beat 2.
    reset_dut();
    run_burst(1'b0, 4, 1'b0, 1'b0, 2);
    chk("flush_fill", bus.fill_level, 2);
    drain();

    // Reset at beat 2 with s0 still transferring.
    reset_dut();
    d0 = DW'($urandom);
    bus.s0_state = TR;
    bus.s0_data = d0;
    bus.s1_state = idle_st();
    cycle(1'b1, {1'b0, d0}, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete();
    exp_ovf = 1'b0;
    exp_short = 1'b0;
    chk("midrst_fill", bus.fill_level, 0);
    chk("midrst_done", bus.burst_done, 0);
    run_burst(1'b0, 4, 1'b0, 1'b0, 0);
    chk("midrst_refill", bus.fill_level, 4);
    drain();

    // Random bursts.
    for (int i = 0; i < 12; i++) begin
      run_burst(1'($urandom), int'($urandom_range(1, 6)), 1'($urandom), 1'b0, 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
